// File: rtl/sync_fifo_flex_if.sv
// Bundle of the write/read handshake and status signals of sync_fifo_flex.
// The FIFO end is the slave modport and the traffic source/sink is the master.
interface sync_fifo_flex_if #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a write is accepted on a rising edge where wr_en=1 and wr_full=0.
  // A read is accepted on a rising edge where rd_en=1 and rd_empty=0.
  // wr_full/rd_empty act as the registered "ready" terms; requests made while
  // they are asserted are dropped and flagged through overflow/underflow.
  logic              wr_en;
  logic [DWIDTH-1:0] wr_data;
  logic              wr_full;
  logic              wr_afull;
  logic              rd_en;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_empty;
  logic              rd_aempty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_full, wr_afull, rd_data, rd_empty, rd_aempty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_full, wr_afull, rd_data, rd_empty, rd_aempty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with optional first-word-fall-through output, occupancy
// count, programmable almost-full/almost-empty and sticky error flags.
module sync_fifo_flex #(
  parameter int DWIDTH        = 64,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_flex_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     count_q, count_nxt;
  logic [DWIDTH-1:0] rd_data_q;
  logic              full_q, afull_q, empty_q, aempty_q, ovf_q, unf_q;
  logic              wr_acc, rd_acc, ram_empty, mem_we, mem_re, bypass;

  always_comb begin
    wr_acc    = bus.wr_en & ~full_q;
    rd_acc    = bus.rd_en & ~empty_q;
    ram_empty = (wr_ptr == rd_ptr);
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    bypass    = 1'b0;
    if (FWFT != 0) begin
      // The output register is vacant or being consumed: refill it from the
      // RAM, or straight from the write port when the RAM holds nothing.
      if (empty_q | rd_acc) begin
        mem_re = ~ram_empty;
        bypass = ram_empty & wr_acc;
        mem_we = wr_acc & ~ram_empty;
      end else begin
        mem_we = wr_acc;
      end
    end else begin
      mem_we = wr_acc;
      mem_re = rd_acc;
    end
    count_nxt = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + PW'(1);
      2'b01:   count_nxt = count_q - PW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Storage has no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (mem_we) wr_ptr <= wr_ptr + PW'(1);
      if (mem_re) begin
        rd_data_q <= mem[rd_ptr[AW-1:0]];
        rd_ptr    <= rd_ptr + PW'(1);
      end else if (bypass) begin
        rd_data_q <= bus.wr_data;
      end
      count_q  <= count_nxt;
      full_q   <= (count_nxt == PW'(DEPTH));
      empty_q  <= (count_nxt == '0);
      afull_q  <= (count_nxt >= PW'(AFULL_THRESH));
      aempty_q <= (count_nxt <= PW'(AEMPTY_THRESH));
      ovf_q    <= ovf_q | (bus.wr_en & full_q);
      unf_q    <= unf_q | (bus.rd_en & empty_q);
    end
  end

  assign bus.wr_full   = full_q;
  assign bus.wr_afull  = afull_q;
  assign bus.rd_empty  = empty_q;
  assign bus.rd_aempty = aempty_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised FIFO; the synchronous successor to the dual-clock FIFO used in the traffic engine.
- Adds a selectable first-word-fall-through (FWFT) read mode, an occupancy count, and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags.
- Sits between traffic-engine pipeline stages that share one clock domain, where rate smoothing and backpressure thresholds are needed.

Parameters:
- DWIDTH, 64, data word width in bits (>=1).
- DEPTH, 16, storage depth in words; power of two, >=4.
- FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2, wr_afull asserts when count >= AFULL_THRESH (range 1..DEPTH).
- AEMPTY_THRESH, 2, rd_aempty asserts when count <= AEMPTY_THRESH (range 0..DEPTH-1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DWIDTH  write data.
- wr_full  out  1  FIFO holds DEPTH words.
- wr_afull  out  1  count >= AFULL_THRESH.
- rd_en  in  1  read request (FWFT=1: pop/acknowledge of the head word).
- rd_data  out  DWIDTH  read data.
- rd_empty  out  1  no readable word.
- rd_aempty  out  1  count <= AEMPTY_THRESH.
- count  out  $clog2(DEPTH)+1  words written and not yet read.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset values: wr_full=0, wr_afull=0 (1 if AFULL_THRESH==0 is disallowed), rd_empty=1, rd_aempty=1, count=0, rd_data=0, overflow=0, underflow=0.
- Reset mid-operation discards all stored words and zeroes the pointers; sticky flags also clear.
- Accepted write = wr_en & ~wr_full. A write is rejected when full even if rd_en is high in the same cycle.
- Accepted read = rd_en & ~rd_empty.
- Rejected write: data is dropped and overflow sets. Rejected read: rd_data holds its value and underflow sets. Both flags remain set until rst.
- count updates on the edge of the accepted operation(s): +1 write only, -1 read only, unchanged when both occur.
- All status outputs are registered and consistent with count in the same cycle: wr_full = (count==DEPTH), rd_empty = (count==0).
- Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; the extra MSB disambiguates full from empty.
- Standard mode (FWFT=0):
  - Read accepted at edge k: rd_data is valid after edge k and holds until the next accepted read.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - Whenever rd_empty=0, rd_data presents the head word; an accepted rd_en advances to the next word after the edge.
  - Write into an empty FIFO at edge k: rd_empty=0 and rd_data=that word after edge k (write-through bypass, 1-cycle latency).
  - Simultaneous read and write with count==1: after the edge, rd_data shows the newly written word and rd_empty stays 0.
- Storage is inferred RAM with registered read, plus an output/bypass register in FWFT mode; count includes the word held in the output register.
- No combinational path from wr_en or rd_en to any output.

Test Plan:
- DEPTH=16, FWFT=0: write 0..15 on consecutive cycles -> wr_full=1 after 16th edge, count=16, wr_afull=1 from count=14. Then read 16 -> rd_data 0..15, each 1 cycle after rd_en; rd_empty=1 after last read.
- FWFT=1, empty FIFO: write 0xA5 at edge k -> rd_empty=0 and rd_data=0xA5 after edge k. Pulse rd_en -> rd_empty=1 and count=0.
- Full FIFO: assert wr_en and rd_en together -> write rejected, overflow=1, count=15 after edge, no stored word corrupted. Empty FIFO: rd_en -> underflow=1, rd_data unchanged.
- Continuous simultaneous read/write at count=8 for 100 cycles -> count stays 8, output sequence equals input sequence delayed by 8 words, pointers wrap with no loss.
- Thresholds AFULL_THRESH=12, AEMPTY_THRESH=3: fill and drain -> wr_afull toggles exactly at count 12, rd_aempty exactly at count 3, in both directions.
- Assert rst with count=10 and overflow=1 -> next cycle count=0, rd_empty=1, overflow=0. A subsequent write/read returns only post-reset data.
